// File: rtl/sram_axi_bridge.sv
// SRAM-style instruction/data request ports bridged onto a single AXI master.
// One outstanding read (inst or data) and one outstanding write at a time.
module sram_axi_bridge (
  input  logic        aclk,
  input  logic        aresetn,
  // instruction port (read-only)
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} wstate_t;

  rstate_t     r_state, r_next;
  wstate_t     w_state, w_next;

  logic        rd_id;          // 0 = instruction, 1 = data
  logic [31:0] rd_addr;
  logic [1:0]  rd_size;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_size;
  logic [3:0]  wr_strb;
  logic        aw_done;
  logic        w_done;

  logic        data_rd_accept;
  logic        inst_rd_accept;
  logic        data_wr_accept;
  logic        read_done;
  logic        write_done;

  // Response ids/status carry no information this bridge acts on.
  logic        unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  // Request arbitration; gated by aresetn so no accept is seen while in reset.
  always_comb begin
    data_rd_accept = aresetn & data_req & ~data_wr
                     & (r_state == R_IDLE) & (w_state == W_IDLE);
    inst_rd_accept = aresetn & inst_req & (r_state == R_IDLE) & ~data_rd_accept;
    data_wr_accept = aresetn & data_req & data_wr & (w_state == W_IDLE)
                     & ((r_state == R_IDLE) | ~rd_id);
    inst_addr_ok   = inst_rd_accept;
    data_addr_ok   = data_rd_accept | data_wr_accept;
  end

  // State registers for both channels.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Read FSM next-state and handshake outputs.
  always_comb begin
    r_next    = r_state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    read_done = 1'b0;
    case (r_state)
      R_IDLE: if (data_rd_accept || inst_rd_accept) r_next = R_ADDR;
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) r_next = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) begin
          read_done = 1'b1;
          r_next    = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write FSM next-state and handshake outputs; AW and W retire independently.
  always_comb begin
    w_next     = w_state;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    write_done = 1'b0;
    case (w_state)
      W_IDLE: if (data_wr_accept) w_next = W_SEND;
      W_SEND: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
        if ((aw_done || awready) && (w_done || wready)) w_next = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          write_done = 1'b1;
          w_next     = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Request latches and per-channel write completion flags.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_id   <= 1'b0;
      rd_addr <= '0;
      rd_size <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_size <= '0;
      wr_strb <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (data_rd_accept || inst_rd_accept) begin
        rd_id   <= data_rd_accept;
        rd_addr <= data_rd_accept ? data_addr : inst_addr;
        rd_size <= data_rd_accept ? data_size : inst_size;
      end
      if (data_wr_accept) begin
        wr_addr <= data_addr;
        wr_data <= data_wdata;
        wr_size <= data_size;
        wr_strb <= data_wstrb;
      end
      // Flags only live while still in W_SEND; they self-clear on exit.
      aw_done <= (w_next == W_SEND) & (aw_done | (awvalid & awready));
      w_done  <= (w_next == W_SEND) & (w_done  | (wvalid  & wready));
    end
  end

  // Fixed single-beat AXI attributes and response steering.
  always_comb begin
    arid    = {3'b000, rd_id};
    araddr  = rd_addr;
    arlen   = '0;
    arsize  = {1'b0, rd_size};
    arburst = 2'b01;
    arlock  = '0;
    arcache = '0;
    arprot  = '0;
    awid    = 4'd1;
    awaddr  = wr_addr;
    awlen   = '0;
    awsize  = {1'b0, wr_size};
    awburst = 2'b01;
    awlock  = '0;
    awcache = '0;
    awprot  = '0;
    wid     = 4'd1;
    wdata   = wr_data;
    wstrb   = wr_strb;
    wlast   = 1'b1;
    inst_data_ok = read_done & ~rd_id;
    data_data_ok = (read_done & rd_id) | write_done;
    inst_rdata   = (read_done & ~rd_id) ? rdata : '0;
    data_rdata   = (read_done &  rd_id) ? rdata : '0;
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: the AXI slave side is driven by hand,
// inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_sram_axi_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int failures = 0;

  sram_axi_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h40; data_req = 1'b1; data_wr = 1'b1;
    #2;
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%b exp=0", arvalid); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL rst_rready got=%b exp=0", rready); end
    checks++; if ({awvalid, wvalid, bready} !== 3'b000) begin failures++; $display("FAIL rst_wr_ctrl got=%b exp=000", {awvalid, wvalid, bready}); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL rst_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL rst_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
    step(); step();
    inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; inst_addr = '0;
    aresetn = 1'b1;
    mid();
    checks++; if (araddr !== 32'h0) begin failures++; $display("FAIL rst_araddr got=%h exp=00000000", araddr); end
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL rst_idle_arvalid got=%b exp=0", arvalid); end
    step();
  endtask

  task automatic test_inst_read();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_size = 2'd2;
    mid();
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL ir_addr_ok got=%b exp=1", inst_addr_ok); end
    checks++; if (arvalid !== 1'b0) begin failures++; $display("FAIL ir_arvalid_n got=%b exp=0", arvalid); end
    step();
    inst_req = 1'b0; inst_addr = '0; arready = 1'b1;
    mid();
    checks++; if (arvalid !== 1'b1) begin failures++; $display("FAIL ir_arvalid got=%b exp=1", arvalid); end
    checks++; if (araddr !== 32'h1C00_0000) begin failures++; $display("FAIL ir_araddr got=%h exp=1c000000", araddr); end
    checks++; if (arid !== 4'd0) begin failures++; $display("FAIL ir_arid got=%h exp=0", arid); end
    checks++; if ({arlen, arsize, arburst} !== {8'd0, 3'd2, 2'b01}) begin failures++; $display("FAIL ir_arfields got=%h exp=%h", {arlen, arsize, arburst}, {8'd0, 3'd2, 2'b01}); end
    checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL ir_addr_ok_busy got=%b exp=0", inst_addr_ok); end
    step();
    arready = 1'b0;
    mid();
    checks++; if ({arvalid, rready, inst_data_ok} !== 3'b010) begin failures++; $display("FAIL ir_wait got=%b exp=010", {arvalid, rready, inst_data_ok}); end
    step();
    rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 32'h1234_5678;
    mid();
    checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL ir_data_ok got=%b exp=1", inst_data_ok); end
    checks++; if (inst_rdata !== 32'h1234_5678) begin failures++; $display("FAIL ir_rdata got=%h exp=12345678", inst_rdata); end
    checks++; if ({data_data_ok, data_rdata} !== 33'd0) begin failures++; $display("FAIL ir_data_port got=%h exp=0", {data_data_ok, data_rdata}); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    mid();
    checks++; if ({inst_data_ok, inst_rdata} !== 33'd0) begin failures++; $display("FAIL ir_after got=%h exp=0", {inst_data_ok, inst_rdata}); end
    checks++; if (rready !== 1'b0) begin failures++; $display("FAIL ir_rready_idle got=%b exp=0", rready); end
    step();
  endtask

  task automatic test_priority();
    inst_req = 1'b1; inst_addr = 32'h0000_1000; inst_size = 2'd2;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_2000; data_size = 2'd1;
    mid();
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin failures++; $display("FAIL pr_tie got=%b exp=10", {data_addr_ok, inst_addr_ok}); end
    step();
    data_req = 1'b0; arready = 1'b1;
    mid();
    checks++; if ({araddr, arid, arsize} !== {32'h2000, 4'd1, 3'd1}) begin failures++; $display("FAIL pr_data_ar got=%h exp=%h", {araddr, arid, arsize}, {32'h2000, 4'd1, 3'd1}); end
    checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL pr_inst_held got=%b exp=0", inst_addr_ok); end
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 32'hCAFE_F00D;
    mid();
    checks++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin failures++; $display("FAIL pr_data_ok got=%b exp=100", {data_data_ok, inst_data_ok, inst_addr_ok}); end
    checks++; if (data_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL pr_data_rdata got=%h exp=cafef00d", data_rdata); end
    checks++; if (inst_rdata !== 32'h0) begin failures++; $display("FAIL pr_inst_rdata got=%h exp=0", inst_rdata); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    mid();
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL pr_inst_accept got=%b exp=1", inst_addr_ok); end
    step();
    inst_req = 1'b0; arready = 1'b1;
    mid();
    checks++; if ({arvalid, araddr, arid} !== {1'b1, 32'h1000, 4'd0}) begin failures++; $display("FAIL pr_inst_ar got=%h exp=%h", {arvalid, araddr, arid}, {1'b1, 32'h1000, 4'd0}); end
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 32'h0000_55AA;
    mid();
    checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h55AA}) begin failures++; $display("FAIL pr_inst_data got=%h exp=%h", {inst_data_ok, inst_rdata}, {1'b1, 32'h55AA}); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
  endtask

  task automatic test_write();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h80; data_size = 2'd2;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF;
    mid();
    checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL wr_addr_ok got=%b exp=1", data_addr_ok); end
    step();
    data_req = 1'b0; data_wr = 1'b0; awready = 1'b1; wready = 1'b0;
    mid();
    checks++; if ({awvalid, wvalid} !== 2'b11) begin failures++; $display("FAIL wr_both_valid got=%b exp=11", {awvalid, wvalid}); end
    checks++; if ({awaddr, awid, awsize, awlen, awburst} !== {32'h80, 4'd1, 3'd2, 8'd0, 2'b01}) begin failures++; $display("FAIL wr_aw_fields got=%h exp=%h", {awaddr, awid, awsize, awlen, awburst}, {32'h80, 4'd1, 3'd2, 8'd0, 2'b01}); end
    checks++; if ({wdata, wstrb, wid, wlast} !== {32'hDEAD_BEEF, 4'hF, 4'd1, 1'b1}) begin failures++; $display("FAIL wr_w_fields got=%h exp=%h", {wdata, wstrb, wid, wlast}, {32'hDEAD_BEEF, 4'hF, 4'd1, 1'b1}); end
    step();
    awready = 1'b0; wready = 1'b1;
    mid();
    checks++; if ({awvalid, wvalid, data_data_ok} !== 3'b010) begin failures++; $display("FAIL wr_aw_dropped got=%b exp=010", {awvalid, wvalid, data_data_ok}); end
    step();
    wready = 1'b0;
    mid();
    checks++; if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0010) begin failures++; $display("FAIL wr_resp_wait got=%b exp=0010", {awvalid, wvalid, bready, data_data_ok}); end
    step();
    bvalid = 1'b1; bid = 4'd1;
    mid();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin failures++; $display("FAIL wr_data_ok got=%b exp=10", {data_data_ok, inst_data_ok}); end
    checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL wr_rdata_zero got=%h exp=0", data_rdata); end
    step();
    bvalid = 1'b0;
    mid();
    checks++; if ({bready, data_data_ok, awvalid, wvalid} !== 4'b0000) begin failures++; $display("FAIL wr_idle got=%b exp=0000", {bready, data_data_ok, awvalid, wvalid}); end
    step();
  endtask

  task automatic test_raw_hazard();
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h100; data_wdata = 32'h0BAD_F00D; data_wstrb = 4'h3;
    step();
    data_wr = 1'b0; data_addr = 32'h300; awready = 1'b1; wready = 1'b1;
    mid();
    checks++; if ({data_addr_ok, awvalid, wvalid} !== 3'b011) begin failures++; $display("FAIL raw_send got=%b exp=011", {data_addr_ok, awvalid, wvalid}); end
    step();
    awready = 1'b0; wready = 1'b0;
    mid();
    checks++; if ({data_addr_ok, bready} !== 2'b01) begin failures++; $display("FAIL raw_resp got=%b exp=01", {data_addr_ok, bready}); end
    step();
    bvalid = 1'b1;
    mid();
    checks++; if ({data_addr_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL raw_bvalid got=%b exp=01", {data_addr_ok, data_data_ok}); end
    step();
    bvalid = 1'b0;
    mid();
    checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL raw_read_accept got=%b exp=1", data_addr_ok); end
    step();
    data_req = 1'b0; arready = 1'b1;
    mid();
    checks++; if ({araddr, arid} !== {32'h300, 4'd1}) begin failures++; $display("FAIL raw_ar got=%h exp=%h", {araddr, arid}, {32'h300, 4'd1}); end
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 32'h0000_0003;
    mid();
    checks++; if ({data_data_ok, data_rdata} !== {1'b1, 32'h3}) begin failures++; $display("FAIL raw_read_data got=%h exp=%h", {data_data_ok, data_rdata}, {1'b1, 32'h3}); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
  endtask

  task automatic test_write_vs_read();
    // write may overlap an instruction read
    inst_req = 1'b1; inst_addr = 32'h500;
    step();
    inst_req = 1'b0; data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h600; data_wdata = 32'h6;
    mid();
    checks++; if ({data_addr_ok, arvalid} !== 2'b11) begin failures++; $display("FAIL wvr_inst_overlap got=%b exp=11", {data_addr_ok, arvalid}); end
    step();
    data_req = 1'b0; awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    mid();
    checks++; if ({data_data_ok, inst_data_ok} !== 2'b10) begin failures++; $display("FAIL wvr_wr_done got=%b exp=10", {data_data_ok, inst_data_ok}); end
    step();
    bvalid = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 32'h0000_0500;
    mid();
    checks++; if ({inst_data_ok, inst_rdata} !== {1'b1, 32'h500}) begin failures++; $display("FAIL wvr_inst_data got=%h exp=%h", {inst_data_ok, inst_rdata}, {1'b1, 32'h500}); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    // write must wait behind an outstanding data read
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h700;
    step();
    data_wr = 1'b1; arready = 1'b1;
    mid();
    checks++; if (data_addr_ok !== 1'b0) begin failures++; $display("FAIL wvr_blocked_addr got=%b exp=0", data_addr_ok); end
    step();
    arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rid = 4'd1; rdata = 32'h7;
    mid();
    checks++; if ({data_addr_ok, data_data_ok} !== 2'b01) begin failures++; $display("FAIL wvr_blocked_data got=%b exp=01", {data_addr_ok, data_data_ok}); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    mid();
    checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL wvr_wr_accept got=%b exp=1", data_addr_ok); end
    step();
    data_req = 1'b0; data_wr = 1'b0; awready = 1'b1; wready = 1'b1;
    step();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b1;
    step();
    bvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    inst_req = 1'b1; inst_addr = 32'h900;
    step();
    inst_req = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0;
    mid();
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rm_in_rdata got=%b exp=1", rready); end
    step();
    aresetn = 1'b0;
    #1;
    checks++; if ({arvalid, rready} !== 2'b00) begin failures++; $display("FAIL rm_async got=%b exp=00", {arvalid, rready}); end
    step(); step();
    aresetn = 1'b1; rvalid = 1'b1; rlast = 1'b1; rid = 4'd0; rdata = 32'hBADD_BADD;
    mid();
    checks++; if ({inst_data_ok, data_data_ok, rready} !== 3'b000) begin failures++; $display("FAIL rm_stale got=%b exp=000", {inst_data_ok, data_data_ok, rready}); end
    checks++; if (inst_rdata !== 32'h0) begin failures++; $display("FAIL rm_stale_rdata got=%h exp=0", inst_rdata); end
    step();
    rvalid = 1'b0; rlast = 1'b0; rdata = '0;
    mid();
    checks++; if ({arvalid, inst_data_ok} !== 2'b00) begin failures++; $display("FAIL rm_idle got=%b exp=00", {arvalid, inst_data_ok}); end
    step();
  endtask

  initial begin
    inst_req = 1'b0; inst_size = 2'd2; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    test_reset();
    test_inst_read();
    test_priority();
    test_write();
    test_raw_hazard();
    test_write_vs_read();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameters: none; all AXI widths fixed (ID 4, addr 32, data 32, len 8).
REQ-002 aclk  in  1  sole clock; all state updates on rising edge.
REQ-003 aresetn  in  1  asynchronous, active-low reset.
REQ-004 inst_req/inst_size[1:0]/inst_addr[31:0]  in  instruction read request (read-only port).
REQ-005 inst_addr_ok/inst_data_ok  out  1  request accepted / read data returned (1-cycle pulses); inst_rdata  out  32.
REQ-006 data_req/data_wr/data_size[1:0]/data_addr[31:0]/data_wstrb[3:0]/data_wdata[31:0]  in  data request.
REQ-007 data_addr_ok/data_data_ok  out  1  (1-cycle pulses); data_rdata  out  32.
REQ-008 AXI master channels ar/r/aw/w/b  out/in  full field set (arid..arprot, arvalid/arready, rid/rdata/rresp/rlast/rvalid/rready, awid..awprot, awvalid/awready, wid/wdata/wstrb/wlast/wvalid/wready, bid/bresp/bvalid/bready).

Function
REQ-009 Read FSM states R_IDLE, R_ADDR, R_DATA; write FSM states W_IDLE, W_SEND, W_RESP; one outstanding read and one outstanding write max.
REQ-010 Data read accept: data_addr_ok=1 when data_req & ~data_wr & R_IDLE & W_IDLE (no read-after-write hazard).
REQ-011 Inst read accept: inst_addr_ok=1 when inst_req & R_IDLE & no data read accept that cycle (data port wins ties).
REQ-012 Data write accept: data_addr_ok=1 when data_req & data_wr & W_IDLE & (R_IDLE or outstanding read id=0).
REQ-013 On read accept: latch addr, size, id (0=inst, 1=data); R_IDLE->R_ADDR next edge.
REQ-014 R_ADDR: arvalid=1, fields stable until arready; on arvalid&arready -> R_DATA.
REQ-015 R_DATA: rready=1; on rvalid&rlast -> R_IDLE; same cycle pulse inst_data_ok (rid=0) or data_data_ok (rid=1) and drive rdata on the matching *_rdata.
REQ-016 Fixed AR/AW fields: len=0, size={1'b0,size}, burst=2'b01, lock=0, cache=0, prot=0; awid=wid=1; wlast=1.
REQ-017 On write accept: latch addr, size, wstrb, wdata; W_IDLE->W_SEND.
REQ-018 W_SEND: awvalid and wvalid asserted together; each drops independently after its handshake; both done -> W_RESP (same-cycle handshakes allowed).
REQ-019 W_RESP: bready=1; on bvalid -> W_IDLE and pulse data_data_ok.
REQ-020 rresp/bresp ignored; no error signalling.
REQ-021 Minimum latency: addr_ok cycle N, arvalid cycle N+1, data_ok same cycle as r handshake.
REQ-022 Only one data_data_ok source possible per cycle (guaranteed by REQ-010/012).
REQ-023 *_rdata = 0 when corresponding data_ok is low.

Reset
REQ-024 aresetn low: both FSMs to IDLE, latches cleared, arvalid/awvalid/wvalid/rready/bready=0, all ok pulses 0, immediately (asynchronous).
REQ-025 Reset mid-transaction abandons it; no data_ok issued for it after release.

Verification
REQ-026 inst read 0x1C000000, arready=1, rvalid 2 cycles later rdata=0x12345678 -> araddr=0x1C000000, arid=0, inst_data_ok pulse, inst_rdata=0x12345678.
REQ-027 inst_req and data read same cycle -> data_addr_ok=1, inst_addr_ok=0; inst accepted after data read completes.
REQ-028 data write 0x80 wstrb=0xF, awready one cycle before wready -> single AW, single W, data_data_ok after bvalid only.
REQ-029 data write pending, data read issued -> data_addr_ok held 0 until bvalid handshake, then read accepted.
REQ-030 aresetn low during R_DATA -> arvalid/rready=0 same cycle; after release no stale data_ok.
